id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-select stage that feeds the ALU in the pipelined RISC-V core.
- Registers decoded operands and control from ID.
- Resolves RAW hazards by forwarding from the MEM and WB stages, then drives the ALU's a, b and ALUControl inputs.
- Detects load-use hazards and inserts bubbles itself.

Parameters:
N, 32, datapath width (matches ALU N)
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active high
stall  in  1  hold all EX-stage registers (downstream back-pressure)
flush  in  1  replace next EX contents with a bubble (taken branch/jump)
id_valid  in  1  ID slot holds a real instruction
id_rd1, id_rd2  in  N  register file read data
id_imm  in  N  sign-extended immediate
id_pc  in  N  PC of ID instruction
id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices
id_alu_control  in  3  ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, MIN 110
id_alu_src  in  1  0: b = rs2 value, 1: b = imm
id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump  in  1  control bits
id_result_src  in  2  writeback select, passed through
mem_reg_write  in  1  MEM-stage write enable
mem_rd  in  REG_ADDR_W  MEM-stage destination
mem_result  in  N  MEM-stage ALU result
wb_reg_write  in  1  WB-stage write enable
wb_rd  in  REG_ADDR_W  WB-stage destination
wb_result  in  N  WB-stage writeback value
load_use_hazard  out  1  ID must hold this cycle (IF/ID stall)
alu_a, alu_b  out  N  ALU operands (combinational after forwarding)
alu_control  out  3  registered ALUControl
ex_store_data  out  N  forwarded rs2 value for stores
ex_pc, ex_imm  out  N  registered
ex_rd  out  REG_ADDR_W  registered destination
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump  out  1  registered
ex_result_src  out  2  registered
fwd_a, fwd_b  out  2  forward select: 00 register, 01 WB, 10 MEM

Behaviour:
- Reset is asynchronous on posedge rst.
  - All registered fields go to 0.
  - alu_control = 000 (ADD); ex_valid = 0.
- Latency: one cycle ID to EX. Forwarding muxes and load_use_hazard are combinational from registered state plus the mem_/wb_ inputs.
- Update priority at each clk edge: rst > flush > stall > load_use_hazard > normal load.
  - flush: load a bubble, even if stall is asserted.
  - stall: hold every register unchanged.
  - load_use_hazard (no stall): load a bubble; ID holds, so the instruction re-enters next cycle.
  - normal: capture all id_* fields; ex_valid = id_valid.
- Bubble contents:
  - ex_valid, reg_write, mem_read, mem_write, branch and jump = 0.
  - alu_control = ADD; data fields and rd = 0.
- Forwarding for operand A, using ex_rs1 (operand B identical, using ex_rs2):
  - MEM match = mem_reg_write & mem_rd != 0 & mem_rd == ex_rs1 → select mem_result, fwd_a = 10.
  - Otherwise WB match under the same rules → select wb_result, fwd_a = 01.
  - Otherwise the registered rd1, fwd_a = 00.
  - MEM has priority over WB when both match.
  - x0 is never forwarded.
- alu_a = forwarded rs1.
- alu_b = id_alu_src registered ? ex_imm : forwarded rs2.
- ex_store_data = forwarded rs2, independent of alu_src.
- load_use_hazard = ex_valid & ex_mem_read & ex_rd != 0 & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
  - It is asserted regardless of stall, but only acted on when stall = 0.
- Forward selects are still computed on a bubble (ex_rs = 0), so the result is always 00.
- Reset mid-stall: the asynchronous clear wins immediately; the held instruction is lost.

Decomposition:
- Shared package: ALUControl encodings (ADD..MIN), forward-select encodings (FWD_REG 00, FWD_WB 01, FWD_MEM 10), result_src encodings.
- One sub-module: forward_unit (pure combinational; rs1, rs2, mem/wb rd and write enables in, fwd_a/fwd_b out).
- Register bank and operand muxes stay in id_ex_stage.

Test Plan:
- Reset release: assert rst mid-cycle → all outputs 0, alu_control = 000, ex_valid = 0 before the next clk edge.
- ADD x3,x1,x2 with id_rd1 = 5, id_rd2 = 7 and no hazards → next cycle alu_a = 5, alu_b = 7, alu_control = 000, fwd_a = fwd_b = 00.
- Double-hazard priority:
  - Setup: EX rs1 = 4; mem_rd = 4 with mem_result = 0x11; wb_rd = 4 with wb_result = 0x22; both write enables high.
  - Expect: alu_a = 0x11, fwd_a = 10.
  - Then drop mem_reg_write → alu_a = 0x22, fwd_a = 01.
  - Then rd = 0 cases → fwd_a = 00.
- Load-use:
  - Setup: EX holds lw x5 (mem_read = 1, rd = 5); ID has id_rs2 = 5, id_valid = 1.
  - Expect: load_use_hazard = 1; next cycle ex_valid = 0 with all control bits 0.
  - Then the hazard deasserts and the ID instruction loads the following cycle.
- Stall/flush interaction:
  - stall = 1 for 3 cycles with changing id_* → EX registers unchanged.
  - stall = 1 and flush = 1 together → bubble loaded.
- Immediate path: id_alu_src = 1, imm = 0xFFFFFFF0, rs2 forwarded from MEM = 0x99 → alu_b = 0xFFFFFFF0, ex_store_data = 0x99.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage.
// Holds the ALUControl opcodes, the forward-select codes driven on
// fwd_a/fwd_b, and the writeback result-select codes that pass through
// the stage unchanged.
package id_ex_stage_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_MIN = 3'b110
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Forwarding select logic for the EX stage (purely combinational).
// Ports:
//   rs1, rs2            source register indices of the instruction in EX
//   mem_reg_write/mem_rd  destination of the instruction in MEM
//   wb_reg_write/wb_rd    destination of the instruction in WB
//   fwd_a, fwd_b          operand selects (FWD_REG / FWD_WB / FWD_MEM)
module id_ex_stage_forward_unit
   import id_ex_stage_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
);

   // MEM holds the younger result, so it beats WB. x0 is hardwired to zero
   // and must never pick up a forwarded value.
   function automatic logic [1:0] select_src(input logic [REG_ADDR_W-1:0] rs);
      logic [1:0] sel;
      sel = FWD_REG;
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
         sel = FWD_MEM;
      end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a = select_src(rs1);
      fwd_b = select_src(rs2);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand select.
// Registers decoded operands/control from ID, forwards MEM/WB results into
// the ALU operands, and turns load-use hazards into bubbles.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall, flush        hold EX registers / load a bubble (flush wins)
//   id_*                decoded instruction from ID
//   mem_*, wb_*         destinations and results of the later stages
//   load_use_hazard     ID must hold this cycle
//   alu_a, alu_b, alu_control   ALU inputs
//   ex_store_data       forwarded rs2 for stores
//   ex_*                registered fields passed down the pipe
//   fwd_a, fwd_b        forward selects in use this cycle
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int N          = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [N-1:0]          id_rd1,
   input  logic [N-1:0]          id_rd2,
   input  logic [N-1:0]          id_imm,
   input  logic [N-1:0]          id_pc,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [2:0]            id_alu_control,
   input  logic                  id_alu_src,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_branch,
   input  logic                  id_jump,
   input  logic [1:0]            id_result_src,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [N-1:0]          mem_result,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [N-1:0]          wb_result,
   output logic                  load_use_hazard,
   output logic [N-1:0]          alu_a,
   output logic [N-1:0]          alu_b,
   output logic [2:0]            alu_control,
   output logic [N-1:0]          ex_store_data,
   output logic [N-1:0]          ex_pc,
   output logic [N-1:0]          ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_valid,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_branch,
   output logic                  ex_jump,
   output logic [1:0]            ex_result_src,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
);

   logic                  ex_alu_src;
   logic [N-1:0]          ex_rd1;
   logic [N-1:0]          ex_rd2;
   logic [REG_ADDR_W-1:0] ex_rs1;
   logic [REG_ADDR_W-1:0] ex_rs2;

   logic                  load_bubble;
   logic                  load_en;
   logic [N-1:0]          fwd_rs1_val;
   logic [N-1:0]          fwd_rs2_val;

   // A load in EX whose destination is read by ID cannot be forwarded in
   // time; ID holds while we insert a bubble, so it re-enters next cycle.
   assign load_use_hazard = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                            ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   // flush overrides stall; the hazard bubble only happens when not stalled.
   assign load_bubble = flush | (~stall & load_use_hazard);
   assign load_en     = ~flush & ~stall & ~load_use_hazard;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_branch     <= 1'b0;
         ex_jump       <= 1'b0;
         ex_result_src <= RES_ALU;
         alu_control   <= ALU_ADD;
         ex_alu_src    <= 1'b0;
         ex_rd1        <= '0;
         ex_rd2        <= '0;
         ex_imm        <= '0;
         ex_pc         <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
      end else if (load_bubble) begin
         // rs fields cleared too, so a bubble always forwards FWD_REG
         ex_valid      <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_branch     <= 1'b0;
         ex_jump       <= 1'b0;
         ex_result_src <= RES_ALU;
         alu_control   <= ALU_ADD;
         ex_alu_src    <= 1'b0;
         ex_rd1        <= '0;
         ex_rd2        <= '0;
         ex_imm        <= '0;
         ex_pc         <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
      end else if (load_en) begin
         ex_valid      <= id_valid;
         ex_reg_write  <= id_reg_write;
         ex_mem_read   <= id_mem_read;
         ex_mem_write  <= id_mem_write;
         ex_branch     <= id_branch;
         ex_jump       <= id_jump;
         ex_result_src <= id_result_src;
         alu_control   <= id_alu_control;
         ex_alu_src    <= id_alu_src;
         ex_rd1        <= id_rd1;
         ex_rd2        <= id_rd2;
         ex_imm        <= id_imm;
         ex_pc         <= id_pc;
         ex_rs1        <= id_rs1;
         ex_rs2        <= id_rs2;
         ex_rd         <= id_rd;
      end
   end

   id_ex_stage_forward_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_forward_unit (
      .rs1           (ex_rs1),
      .rs2           (ex_rs2),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
   );

   always_comb begin
      fwd_rs1_val = ex_rd1;
      case (fwd_a)
         FWD_MEM: fwd_rs1_val = mem_result;
         FWD_WB:  fwd_rs1_val = wb_result;
         default: fwd_rs1_val = ex_rd1;
      endcase
   end

   always_comb begin
      fwd_rs2_val = ex_rd2;
      case (fwd_b)
         FWD_MEM: fwd_rs2_val = mem_result;
         FWD_WB:  fwd_rs2_val = wb_result;
         default: fwd_rs2_val = ex_rd2;
      endcase
   end

   // Store data always takes the forwarded rs2, even when the ALU uses imm.
   assign alu_a         = fwd_rs1_val;
   assign alu_b         = ex_alu_src ? ex_imm : fwd_rs2_val;
   assign ex_store_data = fwd_rs2_val;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, id_valid;
   logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]  id_alu_control;
   logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump;
   logic [1:0]  id_result_src;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_result, wb_result;
   logic        load_use_hazard;
   logic [31:0] alu_a, alu_b, ex_store_data, ex_pc, ex_imm;
   logic [2:0]  alu_control;
   logic [4:0]  ex_rd;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
   logic [1:0]  ex_result_src, fwd_a, fwd_b;

   always #5 clk = ~clk;

   id_ex_stage #(.N(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_branch(id_branch), .id_jump(id_jump), .id_result_src(id_result_src),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .load_use_hazard(load_use_hazard), .alu_a(alu_a), .alu_b(alu_b),
      .alu_control(alu_control), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
      .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .ex_jump(ex_jump), .ex_result_src(ex_result_src), .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   // Reference view of the instruction sitting in EX.
   typedef struct {
      logic        valid, rw, mr, mw, br, jp, alu_src;
      logic [1:0]  res;
      logic [2:0]  ctl;
      logic [31:0] rd1, rd2, imm, pc;
      logic [4:0]  rs1, rs2, rd;
   } ex_t;

   ex_t m;
   int  n_assert = 0;
   int  n_fail   = 0;

   function automatic ex_t bubble();
      ex_t b;
      b.valid = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.br = 0; b.jp = 0; b.alu_src = 0;
      b.res = 0; b.ctl = 0; b.rd1 = 0; b.rd2 = 0; b.imm = 0; b.pc = 0;
      b.rs1 = 0; b.rs2 = 0; b.rd = 0;
      return b;
   endfunction

   function automatic logic model_hazard();
      return m.valid && m.mr && (m.rd != 0) && id_valid && ((m.rd == id_rs1) || (m.rd == id_rs2));
   endfunction

   // 2 = from MEM, 1 = from WB, 0 = register file value
   function automatic int src_of(input logic [4:0] rs);
      if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2;
      if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] value_of(input logic [4:0] rs, input logic [31:0] regval);
      int s;
      s = src_of(rs);
      if (s == 2) return mem_result;
      if (s == 1) return wb_result;
      return regval;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) m = bubble();
      else if (flush) m = bubble();
      else if (stall) m = m;
      else if (model_hazard()) m = bubble();
      else begin
         m.valid = id_valid; m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
         m.br = id_branch; m.jp = id_jump; m.alu_src = id_alu_src; m.res = id_result_src;
         m.ctl = id_alu_control; m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm;
         m.pc = id_pc; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_all();
      logic [31:0] st;
      st = value_of(m.rs2, m.rd2);
      chk("hazard", 32'(load_use_hazard), 32'(model_hazard()));
      chk("fwd_a", 32'(fwd_a), 32'(src_of(m.rs1)));
      chk("fwd_b", 32'(fwd_b), 32'(src_of(m.rs2)));
      chk("alu_a", alu_a, value_of(m.rs1, m.rd1));
      chk("alu_b", alu_b, m.alu_src ? m.imm : st);
      chk("store_data", ex_store_data, st);
      chk("alu_control", 32'(alu_control), 32'(m.ctl));
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_rd", 32'(ex_rd), 32'(m.rd));
      chk("ex_ctrl", {26'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump},
          {26'd0, m.valid, m.rw, m.mr, m.mw, m.br, m.jp});
      chk("ex_result_src", 32'(ex_result_src), 32'(m.res));
   endtask

   task automatic clear_id();
      id_valid = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_pc = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_control = 0; id_alu_src = 0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0; id_jump = 0;
      id_result_src = 0;
   endtask

   task automatic clear_fwd();
      mem_reg_write = 0; mem_rd = 0; mem_result = 0;
      wb_reg_write = 0; wb_rd = 0; wb_result = 0;
   endtask

   task automatic rand_inputs();
      id_valid = ($urandom_range(0, 3) != 0);
      id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_pc = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_alu_control = 3'($urandom_range(0, 6)); id_alu_src = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom_range(0, 1)); id_branch = 1'($urandom_range(0, 1));
      id_jump = 1'($urandom_range(0, 1)); id_result_src = 2'($urandom_range(0, 2));
      mem_reg_write = 1'($urandom_range(0, 1)); mem_rd = 5'($urandom_range(0, 7));
      mem_result = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7));
      wb_result = $urandom;
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      rst = 1; stall = 0; flush = 0;
      clear_id(); clear_fwd();
      m = bubble();
      repeat (2) tick();
      rst = 0;

      // load something, then reset mid-cycle
      id_valid = 1; id_pc = 32'h40; id_rd = 5'd9; id_rd1 = 32'h1234; id_reg_write = 1;
      id_alu_control = 3'd3; id_branch = 1;
      tick();
      check_all();
      rst = 1; m = bubble();
      #1;
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk("rst_alu_control", 32'(alu_control), 32'd0);
      chk("rst_pc", ex_pc, 32'd0);
      check_all();
      tick();
      rst = 0;

      // ADD x3,x1,x2
      clear_id();
      id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3; id_rd1 = 32'd5; id_rd2 = 32'd7;
      id_reg_write = 1;
      tick();
      chk("add_a", alu_a, 32'd5);
      chk("add_b", alu_b, 32'd7);
      chk("add_ctl", 32'(alu_control), 32'd0);
      chk("add_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
      check_all();

      // double hazard on rs1 = x4
      id_rs1 = 5'd4; id_rd1 = 32'hAA; id_rd = 5'd8;
      tick();
      mem_reg_write = 1; mem_rd = 5'd4; mem_result = 32'h11;
      wb_reg_write = 1; wb_rd = 5'd4; wb_result = 32'h22;
      #1;
      chk("dh_mem_a", alu_a, 32'h11);
      chk("dh_mem_fwd", 32'(fwd_a), 32'd2);
      mem_reg_write = 0;
      #1;
      chk("dh_wb_a", alu_a, 32'h22);
      chk("dh_wb_fwd", 32'(fwd_a), 32'd1);
      mem_reg_write = 1; mem_rd = 5'd0; wb_rd = 5'd0;
      #1;
      chk("dh_x0_fwd", 32'(fwd_a), 32'd0);
      chk("dh_x0_a", alu_a, 32'hAA);
      check_all();
      clear_fwd();

      // load-use: lw x5 then consumer of x5 on rs2
      clear_id();
      id_valid = 1; id_mem_read = 1; id_rd = 5'd5; id_rs1 = 5'd1; id_reg_write = 1;
      id_result_src = 2'd1;
      tick();
      clear_id();
      id_valid = 1; id_rs1 = 5'd6; id_rs2 = 5'd5; id_rd = 5'd7; id_reg_write = 1; id_pc = 32'h88;
      #1;
      chk("lu_hazard", 32'(load_use_hazard), 32'd1);
      check_all();
      tick();
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      chk("lu_bubble_ctrl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump}, 32'd0);
      chk("lu_cleared", 32'(load_use_hazard), 32'd0);
      check_all();
      tick();
      chk("lu_reload_valid", 32'(ex_valid), 32'd1);
      chk("lu_reload_rd", 32'(ex_rd), 32'd7);
      check_all();

      // stall for 3 cycles with changing ID, then stall+flush
      clear_id();
      id_valid = 1; id_pc = 32'h100; id_rd = 5'd9; id_reg_write = 1;
      tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         id_pc = $urandom; id_rd = 5'($urandom_range(1, 31)); id_rd1 = $urandom;
         tick();
         chk("stall_pc", ex_pc, 32'h100);
         chk("stall_rd", 32'(ex_rd), 32'd9);
         check_all();
      end
      flush = 1;
      tick();
      chk("flush_valid", 32'(ex_valid), 32'd0);
      chk("flush_pc", ex_pc, 32'd0);
      check_all();
      flush = 0;

      // reset while stalled drops the held instruction
      stall = 0;
      id_pc = 32'h200; id_rd = 5'd3;
      tick();
      stall = 1;
      tick();
      rst = 1; m = bubble();
      #1;
      chk("rst_stall_valid", 32'(ex_valid), 32'd0);
      check_all();
      tick();
      rst = 0; stall = 0;

      // immediate operand with rs2 forwarded from MEM
      clear_id();
      id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFF_FFF0; id_rs2 = 5'd6; id_rd2 = 32'h55;
      id_rd = 5'd2; id_mem_write = 1;
      tick();
      mem_reg_write = 1; mem_rd = 5'd6; mem_result = 32'h99;
      #1;
      chk("imm_b", alu_b, 32'hFFFF_FFF0);
      chk("imm_store", ex_store_data, 32'h99);
      chk("imm_fwd_b", 32'(fwd_b), 32'd2);
      check_all();
      clear_fwd();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         if ($urandom_range(0, 49) == 0) begin
            rst = 1; m = bubble();
         end else begin
            rst = 0;
         end
         #1;
         check_all();
         tick();
         check_all();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
